mac_datapath: RTL

//  Multiply-accumulate datapath driven by control_path's en_Mux/en_PPReg/en_FDReg.

---
 rtl/mac_datapath.sv | 107 ++++++++++
 1 files changed

// File: rtl/mac_datapath.sv
// Multiply-accumulate datapath: product register -> accumulator -> final-data register.
// Optional build macro MAC_SATURATE_EN makes the C element clamp to all-ones instead of truncating.
module mac_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int N_TERMS    = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N_TERMS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       readData_A,
  input  logic [DATA_WIDTH-1:0]       readData_B,
  input  logic                        en_PPReg,
  input  logic                        en_Mux,
  input  logic                        en_FDReg,
  output logic [DATA_WIDTH-1:0]       writeData_C,
  output logic                        fd_valid,
  output logic                        ovf_C,
  output logic [$clog2(N_TERMS):0]    term_cnt
);

  localparam int PP_WIDTH  = 2*DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(N_TERMS) + 1;

  logic [PP_WIDTH-1:0]   pp_q, pp_d;
  logic                  pp_vld_q, pp_vld_d;
  logic                  mux_q, mux_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  term_cnt_q, term_cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  fd_valid_q, fd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  acc_over;
  logic [DATA_WIDTH-1:0] acc_narrow;

  // Stage 1: product capture; the valid bit follows en_PPReg on every edge.
  always_comb begin
    pp_d     = pp_q;
    mux_d    = mux_q;
    pp_vld_d = en_PPReg;
    if (en_PPReg) begin
      pp_d  = PP_WIDTH'(readData_A) * PP_WIDTH'(readData_B);
      mux_d = en_Mux;
    end
  end

  // Stage 2: accumulate or restart; term count saturates rather than wrapping.
  always_comb begin
    acc_d      = acc_q;
    term_cnt_d = term_cnt_q;
    if (pp_vld_q) begin
      acc_d = (mux_q ? acc_q : '0) + ACC_WIDTH'(pp_q);
      if (!mux_q) begin
        term_cnt_d = CNT_WIDTH'(1);
      end else if (term_cnt_q != '1) begin
        term_cnt_d = term_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign acc_over = |acc_q[ACC_WIDTH-1:DATA_WIDTH];

`ifdef MAC_SATURATE_EN
  assign acc_narrow = acc_over ? '1 : acc_q[DATA_WIDTH-1:0];
`else
  assign acc_narrow = acc_q[DATA_WIDTH-1:0];
`endif

  // Stage 3 reads acc_q, so a capture coinciding with an accumulate sees the old sum.
  always_comb begin
    wdata_d    = wdata_q;
    ovf_d      = ovf_q;
    fd_valid_d = 1'b0;
    if (en_FDReg) begin
      wdata_d    = acc_narrow;
      ovf_d      = acc_over;
      fd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_q       <= '0;
      pp_vld_q   <= 1'b0;
      mux_q      <= 1'b0;
      acc_q      <= '0;
      term_cnt_q <= '0;
      wdata_q    <= '0;
      fd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pp_q       <= pp_d;
      pp_vld_q   <= pp_vld_d;
      mux_q      <= mux_d;
      acc_q      <= acc_d;
      term_cnt_q <= term_cnt_d;
      wdata_q    <= wdata_d;
      fd_valid_q <= fd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign writeData_C = wdata_q;
  assign fd_valid    = fd_valid_q;
  assign ovf_C       = ovf_q;
  assign term_cnt    = term_cnt_q;

endmodule
